// File: rtl/bram_port_responder.sv
// ============================================================================
// bram_port_responder : responder end of a single-port BRAM interface with
//                       byte-lane writes, 1- or 2-cycle read pipeline and
//                       saturating access statistics.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bram_port_responder #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 20,
  parameter int DEPTH      = 2048,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bram_en,
  input  logic [DATA_W/8-1:0] bram_we,
  input  logic [ADDR_W-1:0]   bram_addr,
  input  logic [DATA_W-1:0]   bram_wdata,
  output logic [DATA_W-1:0]   bram_rdata,
  output logic                rd_valid,
  output logic                addr_err,
  input  logic                clr_stats,
  output logic [31:0]         wr_count,
  output logic [31:0]         rd_count
);

  localparam int                LANES   = DATA_W / 8;
  localparam int                IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic              is_write;
  logic              is_read;
  logic [IDX_W-1:0]  idx;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;

  assign in_range = bram_addr < DEPTH_A;
  assign idx      = bram_addr[IDX_W-1:0];
  assign is_write = bram_en && (bram_we != '0);
  assign is_read  = bram_en && (bram_we == '0);

  // Storage has no reset; accesses presented while rst is low are dropped.
  always_ff @(posedge clk) begin
    if (rst && is_write && in_range) begin
      for (int i = 0; i < LANES; i++) begin
        if (bram_we[i]) mem[idx][i*8 +: 8] <= bram_wdata[i*8 +: 8];
      end
    end
  end

  // First pipeline stage; data only moves on a read so writes/idle hold it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= is_read;
      if (is_read) s1_data <= in_range ? mem[idx] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count <= '0;
      rd_count <= '0;
      addr_err <= 1'b0;
    end else if (clr_stats) begin
      wr_count <= '0;
      rd_count <= '0;
      addr_err <= 1'b0;
    end else begin
      if (is_write && (wr_count != '1)) wr_count <= wr_count + 32'd1;
      if (is_read && (rd_count != '1))  rd_count <= rd_count + 32'd1;
      if (bram_en && !in_range)         addr_err <= 1'b1;
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic              out_valid;
      logic [DATA_W-1:0] out_data;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          out_valid <= 1'b0;
          out_data  <= '0;
        end else begin
          out_valid <= s1_valid;
          if (s1_valid) out_data <= s1_data;
        end
      end

      assign rd_valid   = out_valid;
      assign bram_rdata = out_data;
    end else begin : g_lat1
      assign rd_valid   = s1_valid;
      assign bram_rdata = s1_data;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_bram_port_responder.sv
// ============================================================================
// tb_bram_port_responder : directed self-checking bench, latency 1 and 2 DUTs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bram_port_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        bram_en;
  logic [1:0]  bram_we;
  logic [19:0] bram_addr;
  logic [15:0] bram_wdata;
  logic        clr_stats;

  logic [15:0] rdata1, rdata2;
  logic        valid1, valid2;
  logic        err1, err2;
  logic [31:0] wrc1, wrc2, rdc1, rdc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_port_responder #(.DATA_W(16), .ADDR_W(20), .DEPTH(2048), .RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_rdata(rdata1),
    .rd_valid(valid1), .addr_err(err1), .clr_stats(clr_stats),
    .wr_count(wrc1), .rd_count(rdc1)
  );

  bram_port_responder #(.DATA_W(16), .ADDR_W(20), .DEPTH(2048), .RD_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_rdata(rdata2),
    .rd_valid(valid2), .addr_err(err2), .clr_stats(clr_stats),
    .wr_count(wrc2), .rd_count(rdc2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs set before this are sampled there.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [1:0] we, input logic [19:0] a,
                       input logic [15:0] d);
    bram_en    = en;
    bram_we    = we;
    bram_addr  = a;
    bram_wdata = d;
  endtask

  initial begin
    rst = 1'b0;
    clr_stats = 1'b0;
    drive(1'b0, 2'b00, 20'd0, 16'd0);
    cyc();
    cyc();
    check("rst_rdata", {16'd0, rdata1}, 32'd0);
    check("rst_valid", {31'd0, valid1}, 32'd0);
    check("rst_err", {31'd0, err1}, 32'd0);
    check("rst_wrc", wrc1, 32'd0);
    check("rst_rdc", rdc1, 32'd0);
    check("rst_l2_cnt", wrc2 | rdc2 | {31'd0, err2}, 32'd0);
    rst = 1'b1;

    // Full write then read with latency check on both pipelines
    drive(1'b1, 2'b11, 20'd5, 16'hA5A5);
    cyc();
    check("wr_no_valid", {31'd0, valid1}, 32'd0);
    drive(1'b1, 2'b00, 20'd5, 16'h0000);
    cyc();
    check("rd5_l1_data", {16'd0, rdata1}, 32'h0000_A5A5);
    check("rd5_l1_valid", {31'd0, valid1}, 32'd1);
    check("rd5_l2_early", {31'd0, valid2}, 32'd0);
    drive(1'b0, 2'b00, 20'd0, 16'd0);
    cyc();
    check("rd5_l1_gap", {31'd0, valid1}, 32'd0);
    check("rd5_l1_hold", {16'd0, rdata1}, 32'h0000_A5A5);
    check("rd5_l2_valid", {31'd0, valid2}, 32'd1);
    check("rd5_l2_data", {16'd0, rdata2}, 32'h0000_A5A5);
    check("wrc_1", wrc1, 32'd1);
    check("rdc_1", rdc1, 32'd1);

    // A write must not disturb the read port
    drive(1'b1, 2'b11, 20'd6, 16'h1111);
    cyc();
    check("wr_hold_data", {16'd0, rdata1}, 32'h0000_A5A5);
    check("wr_hold_valid", {31'd0, valid1}, 32'd0);

    // Byte-lane write: only the low lane takes the new value
    drive(1'b1, 2'b11, 20'd7, 16'h1234);
    cyc();
    drive(1'b1, 2'b01, 20'd7, 16'hFFFF);
    cyc();
    drive(1'b1, 2'b00, 20'd7, 16'h0000);
    cyc();
    check("lane_data", {16'd0, rdata1}, 32'h0000_12FF);
    check("lane_valid", {31'd0, valid1}, 32'd1);
    check("wrc_4", wrc1, 32'd4);
    check("rdc_2", rdc1, 32'd2);
    drive(1'b0, 2'b00, 20'd0, 16'd0);
    cyc();

    // Fill every word, then stream reads back-to-back
    for (int i = 0; i < 2048; i++) begin
      drive(1'b1, 2'b11, 20'(i), 16'(i));
      cyc();
    end
    for (int i = 0; i < 2048; i++) begin
      drive(1'b1, 2'b00, 20'(i), 16'd0);
      cyc();
      check("burst_l1_data", {16'd0, rdata1}, 32'(i));
      check("burst_l1_valid", {31'd0, valid1}, 32'd1);
      if (i > 0) check("burst_l2_data", {15'd0, valid2, rdata2}, {15'd0, 1'b1, 16'(i - 1)});
    end
    drive(1'b0, 2'b00, 20'd0, 16'd0);
    cyc();
    check("burst_l2_last", {15'd0, valid2, rdata2}, {15'd0, 1'b1, 16'h07FF});
    check("burst_l1_end", {31'd0, valid1}, 32'd0);
    check("wrc_2052", wrc1, 32'd2052);
    check("rdc_2050", rdc1, 32'd2050);
    check("no_err_yet", {31'd0, err1}, 32'd0);

    // Out-of-range read and write
    drive(1'b1, 2'b00, 20'd2048, 16'd0);
    cyc();
    check("oor_rd_data", {16'd0, rdata1}, 32'd0);
    check("oor_rd_valid", {31'd0, valid1}, 32'd1);
    check("oor_err", {31'd0, err1}, 32'd1);
    check("oor_rdc", rdc1, 32'd2051);
    drive(1'b1, 2'b11, 20'd2048, 16'hDEAD);
    cyc();
    check("oor_wrc", wrc1, 32'd2053);
    drive(1'b1, 2'b00, 20'd0, 16'd0);
    cyc();
    check("oor_no_alias", {16'd0, rdata1}, 32'd0);
    check("err_sticky", {31'd0, err1}, 32'd1);
    drive(1'b0, 2'b00, 20'd0, 16'd0);
    clr_stats = 1'b1;
    cyc();
    clr_stats = 1'b0;
    check("clr_err", {31'd0, err1}, 32'd0);
    check("clr_wrc", wrc1, 32'd0);
    check("clr_rdc", rdc1, 32'd0);

    // Clear coinciding with accesses: access runs, nothing counted or flagged
    drive(1'b1, 2'b11, 20'd3, 16'hBEEF);
    clr_stats = 1'b1;
    cyc();
    drive(1'b1, 2'b00, 20'd4000, 16'd0);
    cyc();
    clr_stats = 1'b0;
    check("clr_wr_uncounted", wrc1, 32'd0);
    check("clr_oor_noerr", {31'd0, err1}, 32'd0);
    check("clr_oor_rd", {15'd0, valid1, rdata1}, {15'd0, 1'b1, 16'd0});
    check("clr_rd_uncounted", rdc1, 32'd0);
    drive(1'b1, 2'b00, 20'd3, 16'd0);
    cyc();
    check("clr_wr_data", {16'd0, rdata1}, 32'h0000_BEEF);
    check("rdc_after_clr", rdc1, 32'd1);

    // Reset with a read in flight in the two-stage pipeline
    drive(1'b1, 2'b00, 20'd5, 16'd0);
    cyc();
    drive(1'b1, 2'b11, 20'd7, 16'hFFFF);
    rst = 1'b0;
    #1;
    check("arst_l2_valid", {31'd0, valid2}, 32'd0);
    check("arst_l2_data", {16'd0, rdata2}, 32'd0);
    check("arst_l1_data", {16'd0, rdata1}, 32'd0);
    cyc();
    rst = 1'b1;
    drive(1'b0, 2'b00, 20'd0, 16'd0);
    cyc();
    check("flush_l2_a", {31'd0, valid2}, 32'd0);
    cyc();
    check("flush_l2_b", {31'd0, valid2}, 32'd0);
    check("rst_wr_ignored", wrc1, 32'd0);

    // Storage survives reset and the write presented during reset was dropped
    drive(1'b1, 2'b00, 20'd7, 16'd0);
    cyc();
    check("mem_kept", {15'd0, valid1, rdata1}, {15'd0, 1'b1, 16'd7});
    drive(1'b0, 2'b00, 20'd0, 16'd0);
    cyc();
    check("mem_kept_l2", {15'd0, valid2, rdata2}, {15'd0, 1'b1, 16'd7});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bram_port_responder.md
BRAM_PORT_RESPONDER -- requirements
Module: bram_port_responder

Interface
REQ-001 Parameters, one per line (name, default, meaning) SHALL be:
  DATA_W, 16, data width, multiple of 8.
  ADDR_W, 20, word-address width.
  DEPTH, 2048, number of implemented words.
  RD_LATENCY, 1, read latency in cycles; legal values 1 or 2.
REQ-002 Ports, one per line (name, direction, width, meaning) SHALL be:
  clk  input  1  clock, all logic on rising edge.
  rst  input  1  reset, asynchronous, active-low.
  bram_en  input  1  access enable from initiator.
  bram_we  input  DATA_W/8  byte write enables; all-zero with bram_en=1 means read.
  bram_addr  input  ADDR_W  word address.
  bram_wdata  input  DATA_W  write data.
  bram_rdata  output  DATA_W  read data.
  rd_valid  output  1  one-cycle pulse; bram_rdata valid this cycle.
  addr_err  output  1  sticky out-of-range access flag.
  clr_stats  input  1  synchronous clear of counters and addr_err.
  wr_count  output  32  accepted write count.
  rd_count  output  32  accepted read count.

Function
REQ-003 The block SHALL be the responder end of the single-port BRAM interface, accepting one access per cycle with no back-pressure.
REQ-004 Write: bram_en=1, bram_we!=0, bram_addr<DEPTH -> at that edge each byte lane i with bram_we[i]=1 SHALL be stored; other lanes unchanged.
REQ-005 Write cycles SHALL NOT assert rd_valid and SHALL NOT change bram_rdata.
REQ-006 Read: bram_en=1, bram_we=0 -> contents of bram_addr SHALL appear on bram_rdata with rd_valid=1 exactly RD_LATENCY cycles after the sampling edge.
REQ-007 Consecutive reads on every cycle SHALL yield one rd_valid per read, in order, no gaps.
REQ-008 Read of an address written in the previous cycle SHALL return the new data (write precedes read).
REQ-009 bram_en=0 -> no access; bram_rdata SHALL hold its last value; rd_valid=0 for that slot.
REQ-010 Out of range (bram_addr>=DEPTH) with bram_en=1 -> no storage modified; a read SHALL return all zeros with normal rd_valid timing; addr_err SHALL set at that edge and stay set until clr_stats or reset.
REQ-011 Each accepted write (REQ-004 or REQ-010) SHALL increment wr_count by 1; each read SHALL increment rd_count by 1; both SHALL saturate at 0xFFFF_FFFF.
REQ-012 clr_stats=1 SHALL zero wr_count, rd_count, addr_err at that edge; an access in the same cycle SHALL NOT be counted and SHALL NOT set addr_err; the access itself SHALL still execute.
REQ-013 Read pipeline SHALL be a RD_LATENCY-deep shift of {valid, data}; RD_LATENCY=2 adds one output register stage.

Reset
REQ-014 rst=0 SHALL asynchronously force bram_rdata=0, rd_valid=0, addr_err=0, wr_count=0, rd_count=0.
REQ-015 Reset SHALL flush in-flight reads; no rd_valid SHALL appear for reads accepted before or during reset.
REQ-016 Memory contents SHALL NOT be cleared by reset; reads of never-written addresses are undefined.
REQ-017 Inputs sampled while rst=0 SHALL be ignored; first access is accepted on the first rising edge with rst=1.

Verification
REQ-018 Write 0xA5A5 to addr 5 (we=2'b11), then read addr 5 -> bram_rdata=0xA5A5, rd_valid=1 exactly RD_LATENCY cycles after read; wr_count=1, rd_count=1.
REQ-019 Write 0x1234 to addr 7, then write 0xFFFF with we=2'b01, then read -> 0x12FF.
REQ-020 Back-to-back reads addr 0..2047 after writing data=addr[15:0] -> 2048 consecutive rd_valid pulses, data 0x0000..0x07FF in order.
REQ-021 Read addr 2048 -> rdata=0x0000 with rd_valid, addr_err=1, rd_count increments; then clr_stats=1 -> addr_err=0, counters=0.
REQ-022 With RD_LATENCY=2, issue read then assert rst=0 one cycle later -> outputs 0 at once, no rd_valid after rst returns to 1.
REQ-023 clr_stats=1 in the same cycle as a write of 0xBEEF to addr 3 -> wr_count=0 afterward; subsequent read of addr 3 returns 0xBEEF.
